// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq : sequencer between the control unit and the 32-bit iterative
// divider.
//
// Accepts a one-cycle divide request, latches the operands and pulses the
// divider start. It keeps the operands steady while the divider runs, counts
// its iterations and copies the result into the architectural HI/LO
// registers. A zero divisor is caught here and never reaches the divider.
// mthi/mtlo writes are applied only while the sequencer is not busy.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   req          in   divide request pulse (sampled in IDLE only)
//   op_a, op_b   in   dividend / divisor, sampled with req
//   mthi, mtlo   in   write wdata to hi / lo (ignored while busy)
//   wdata        in   data for mthi / mtlo
//   div_hi       in   divider remainder
//   div_lo       in   divider quotient
//   div_start    out  registered start pulse to the divider
//   div_a, div_b out  registered operands, held until the next accepted req
//   busy         out  division in progress
//   done         out  one-cycle completion pulse
//   div_by_zero  out  one-cycle pulse alongside done when op_b == 0
//   hi, lo       out  architectural HI / LO
// ---------------------------------------------------------------------------
module div_seq #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t        r_state,  w_state_nxt;
  logic [CW-1:0] r_count,  w_count_nxt;
  logic          r_start,  w_start_nxt;
  logic [31:0]   r_a,      w_a_nxt;
  logic [31:0]   r_b,      w_b_nxt;
  logic          r_busy,   w_busy_nxt;
  logic          r_done,   w_done_nxt;
  logic          r_dbz,    w_dbz_nxt;
  logic [31:0]   r_hi,     w_hi_nxt;
  logic [31:0]   r_lo,     w_lo_nxt;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_start_nxt = r_start;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_dbz_nxt   = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;

    // Register moves are only legal while idle; the control unit stalls on
    // busy, so anything arriving during a division is simply dropped.
    if (!r_busy) begin
      if (mthi) w_hi_nxt = wdata;
      if (mtlo) w_lo_nxt = wdata;
    end

    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          if (op_b != 32'd0) begin
            w_a_nxt     = op_a;
            w_b_nxt     = op_b;
            w_start_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_START;
          end else begin
            // Zero divisor: answer straight away without starting the
            // divider; its own sticky zero flag is never consulted.
            w_done_nxt = 1'b1;
            w_dbz_nxt  = 1'b1;
          end
        end
      end

      S_START: begin
        // The divider sees the start pulse on this edge, which is its first
        // iteration; DIV_CYCLES-1 more edges follow before results settle.
        w_start_nxt = 1'b0;
        w_count_nxt = CW'(DIV_CYCLES - 1);
        w_state_nxt = S_RUN;
      end

      S_RUN: begin
        if (r_count != '0) begin
          w_count_nxt = r_count - CW'(1);
        end else begin
          w_hi_nxt    = div_hi;
          w_lo_nxt    = div_lo;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_start <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_start <= w_start_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_dbz   <= w_dbz_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign div_start   = r_start;
  assign div_a       = r_a;
  assign div_b       = r_b;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
